// File: rtl/timer_scheduler.sv
// Round-robin time-sharing of a single interval timer among N_REQ requesters.
// Drives the timer's activate input and holds expiry until the owner acknowledges it.
module timer_scheduler #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] ack,
    input  logic             timer_done,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] expired,
    output logic             timer_activate,
    output logic             busy,
    output logic [OW-1:0]    owner
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]    state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] next_owner;
    logic [OW-1:0] cand;
    logic          found;

    // Search starts one past the last owner and wraps, so a pending channel
    // is served before the previous owner gets the timer again.
    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OW'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                next_owner = cand;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= OW'(N_REQ - 1);
            owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= RUN;
                        owner <= next_owner;
                    end
                end
                RUN: begin
                    // A cancel outranks a completion seen on the same edge.
                    if (!req[owner]) begin
                        state <= RELEASE;
                    end else if (timer_done) begin
                        state <= EXPIRED;
                    end
                end
                EXPIRED: begin
                    if (ack[owner] || !req[owner]) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    ptr   <= owner;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Activate stays high through EXPIRED so the timer keeps its done flag
    // until the owner has consumed it; RELEASE and IDLE give the clear gap.
    always_comb begin
        grant          = '0;
        expired        = '0;
        timer_activate = 1'b0;
        busy           = (state != IDLE);
        if (state == RUN || state == EXPIRED) begin
            grant[owner]   = 1'b1;
            timer_activate = 1'b1;
        end
        if (state == EXPIRED) begin
            expired[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed self-checking bench for timer_scheduler with a behavioural timer model
// that raises done 20 active cycles after activate rises and holds it until activate falls.
module tb_timer_scheduler;

    localparam int N_REQ = 4;
    localparam int OW    = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             timer_done;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] expired;
    logic             timer_activate;
    logic             busy;
    logic [OW-1:0]    owner;

    int   compared   = 0;
    int   mismatched = 0;
    int   tcnt       = 0;
    logic model_done = 1'b0;
    int   n;
    logic [N_REQ-1:0] exp_grant;

    timer_scheduler #(.N_REQ(N_REQ), .OW(OW)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .ack            (ack),
        .timer_done     (timer_done),
        .grant          (grant),
        .expired        (expired),
        .timer_activate (timer_activate),
        .busy           (busy),
        .owner          (owner)
    );

    always #10 clock = ~clock;

    assign timer_done = model_done;

    // Timer model: counter clears whenever activate is sampled low.
    always @(posedge clock) begin
        if (timer_activate !== 1'b1) begin
            tcnt       <= 0;
            model_done <= 1'b0;
        end else begin
            if (tcnt < 20) tcnt <= tcnt + 1;
            if (tcnt == 19) model_done <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N_REQ-1:0] g,
                              input logic [N_REQ-1:0] e, input logic a, input logic b);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_expired"}, 32'(expired), 32'(e));
        check({tag, "_activate"}, 32'(timer_activate), 32'(a));
        check({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic wait_expired(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (expired == '0 && cycles < limit) begin
            tick();
            cycles++;
        end
        check({tag, "_expired_seen"}, 32'(expired != '0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int cycles;
        cycles = 0;
        while (timer_done !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(timer_done), 32'd1);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        req   = '0;
        ack   = '0;
        tick();
        tick();
        reset = 1'b0;
        check_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check("reset_owner", 32'(owner), 32'd0);

        // Single requester: grant, expiry 21 edges after grant, ack, 2-cycle gap, regrant
        req = 4'b0001;
        tick();
        check_outs("t1_grant", 4'b0001, 4'b0000, 1'b1, 1'b1);
        check("t1_owner", 32'(owner), 32'd0);
        wait_expired("t1", 40, n);
        check("t1_latency", 32'(n), 32'd21);
        check_outs("t1_expired", 4'b0001, 4'b0001, 1'b1, 1'b1);
        ack = 4'b0001;
        tick();
        ack = 4'b0000;
        check_outs("t1_release", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        check_outs("t1_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        check_outs("t1_regrant", 4'b0001, 4'b0000, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // All requesting: rotation 0,1,2,3,0 after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_grant = 4'b0001 << (i % 4);
            check("t2_grant", 32'(grant), 32'(exp_grant));
            check("t2_owner", 32'(owner), 32'(i % 4));
            wait_expired("t2", 40, n);
            check("t2_expired", 32'(expired), 32'(exp_grant));
            ack = exp_grant;
            tick();
            ack = 4'b0000;
            tick();
            tick();
        end
        // Now owner 1 in RUN; cancel it so ptr lands on 1
        req = 4'b0000;
        tick();
        tick();

        // Cancel owner 2 after five RUN cycles, next pending after ptr=2 is 3
        req = 4'b1100;
        tick();
        check("t3_grant", 32'(grant), 32'(4'b0100));
        check("t3_owner", 32'(owner), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_no_expired", 32'(expired), 32'd0);
        end
        req = 4'b1011;
        tick();
        check_outs("t3_cancel", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        check("t3_idle_busy", 32'(busy), 32'd0);
        tick();
        check("t3_next_grant", 32'(grant), 32'(4'b1000));
        check("t3_next_owner", 32'(owner), 32'd3);

        // timer_done and cancel seen on the same edge: cancel wins
        wait_done("t4", 40);
        check("t4_not_yet_expired", 32'(expired), 32'd0);
        req = 4'b0011;
        tick();
        check_outs("t4_release", 4'b0000, 4'b0000, 1'b0, 1'b1);
        req = 4'b0001;
        tick();
        tick();
        check("t5_grant", 32'(grant), 32'(4'b0001));

        // Owner ack during RUN and non-owner ack during EXPIRED are ignored
        ack = 4'b0001;
        tick();
        tick();
        tick();
        ack = 4'b0000;
        check_outs("t5_run_ack", 4'b0001, 4'b0000, 1'b1, 1'b1);
        wait_expired("t5", 40, n);
        ack = 4'b0010;
        tick();
        tick();
        check_outs("t5_nonowner_ack", 4'b0001, 4'b0001, 1'b1, 1'b1);
        ack = 4'b0001;
        tick();
        ack = 4'b0000;
        check_outs("t5_release", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();

        // Reset in RUN and in EXPIRED
        req = 4'b0110;
        tick();
        check("t6_grant", 32'(grant), 32'(4'b0010));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_outs("t6_reset_run", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check("t6_reset_run_owner", 32'(owner), 32'd0);
        reset = 1'b0;
        tick();
        check("t6_after_reset_grant", 32'(grant), 32'(4'b0010));
        check("t6_after_reset_owner", 32'(owner), 32'd1);
        wait_expired("t6", 40, n);
        check("t6_expired", 32'(expired), 32'(4'b0010));
        reset = 1'b1;
        tick();
        check_outs("t6_reset_exp", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check("t6_reset_exp_owner", 32'(owner), 32'd0);
        reset = 1'b0;
        req = 4'b1100;
        tick();
        check("t6_final_grant", 32'(grant), 32'(4'b0100));
        check("t6_final_owner", 32'(owner), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
